// File: rtl/injector_scan_sequencer.sv
// injector_scan_sequencer
// Walks comparator_injector across an inclusive halfstrip range. For each
// halfstrip it clears the compout error counter, points the injector at the
// halfstrip, fires one pulse train, waits for the pulser to drop and recover,
// lets the comparators settle, then offers (halfstrip, errcnt) on a
// valid/ready result port. The range wraps 31->0 when hs_first > hs_last.
//
// Build option SCAN_TIMEOUT_EN: when defined, a watchdog bounds the time spent
// waiting on pulser_ready. A halfstrip that does not finish within
// TIMEOUT_CYCLES is reported with errcnt 16'hFFFF and result_timeout set, and
// the scan moves on. When undefined the waits are unbounded and
// result_timeout stays 0.
//
// All outputs are registered. Each output's next value is decoded from the
// next state, so the output and the state it belongs to change on the same edge.

module injector_scan_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  hs_first,
  input  logic [4:0]  hs_last,
  input  logic [7:0]  settle_cycles,
  output logic        busy,
  output logic        done,
  output logic [4:0]  active_halfstrip,
  output logic        compout_errcnt_rst,
  output logic        fire_pulse,
  input  logic        pulser_ready,
  input  logic [15:0] compout_errcnt,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [4:0]  result_halfstrip,
  output logic [15:0] result_errcnt,
  output logic        result_timeout
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_FIRE      = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_SETTLE    = 3'd5,
    S_REPORT    = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  hs_r;
  logic [4:0]  hs_s;
  logic [7:0]  settle_r;
  logic [7:0]  settle_s;
  logic        capture_s;          // normal capture of compout_errcnt
  logic        timeout_capture_s;  // watchdog expiry capture
  logic        done_s;
  logic        tmo_hit_s;

`ifdef SCAN_TIMEOUT_EN
  // Last counter value before expiry: the watchdog fires on its
  // TIMEOUT_CYCLES-th cycle of waiting.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] tmo_cnt_r;
  logic        in_wait_s;

  assign in_wait_s = (state_r == S_WAIT_LOW) || (state_r == S_WAIT_HIGH);
  assign tmo_hit_s = in_wait_s && (tmo_cnt_r == TMO_LAST);

  // Watchdog: counts cycles spent waiting on the pulser for the current halfstrip
  always_ff @(posedge clock) begin
    if (!reset) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_r == S_CLEAR) begin
      tmo_cnt_r <= 16'd0;
    end else if (in_wait_s) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  // No watchdog: the pulser waits are unbounded. TIMEOUT_CYCLES has no
  // effect in this build; it is folded in here only so it stays referenced.
  assign tmo_hit_s = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  // Next-state, halfstrip and settle-counter decode; abort overrides everything
  always_comb begin
    state_s           = state_r;
    hs_s              = hs_r;
    settle_s          = settle_r;
    capture_s         = 1'b0;
    timeout_capture_s = 1'b0;
    done_s            = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          hs_s    = hs_first;
          state_s = S_CLEAR;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_CLEAR: begin
        state_s = S_FIRE;
      end

      S_FIRE: begin
        state_s = S_WAIT_LOW;
      end

      S_WAIT_LOW: begin
        if (tmo_hit_s) begin
          timeout_capture_s = 1'b1;
          state_s           = S_REPORT;
        end else if (!pulser_ready) begin
          state_s = S_WAIT_HIGH;
        end else begin
          state_s = S_WAIT_LOW;
        end
      end

      S_WAIT_HIGH: begin
        if (tmo_hit_s) begin
          timeout_capture_s = 1'b1;
          state_s           = S_REPORT;
        end else if (pulser_ready) begin
          settle_s = settle_cycles;
          state_s  = S_SETTLE;
        end else begin
          state_s = S_WAIT_HIGH;
        end
      end

      S_SETTLE: begin
        // Counter reaching zero ends the settle window; settle_cycles==0
        // therefore captures on the first SETTLE cycle.
        if (settle_r == 8'd0) begin
          capture_s = 1'b1;
          state_s   = S_REPORT;
        end else begin
          settle_s = settle_r - 8'd1;
          state_s  = S_SETTLE;
        end
      end

      S_REPORT: begin
        if (result_ready) begin
          if (hs_r == hs_last) begin
            done_s  = 1'b1;
            state_s = S_IDLE;
          end else begin
            hs_s    = hs_r + 5'd1;
            state_s = S_CLEAR;
          end
        end else begin
          state_s = S_REPORT;
        end
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase

    if (abort && (state_r != S_IDLE)) begin
      state_s           = S_IDLE;
      hs_s              = hs_r;
      settle_s          = settle_r;
      capture_s         = 1'b0;
      timeout_capture_s = 1'b0;
      done_s            = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State, halfstrip, settle counter and all registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r            <= S_IDLE;
      hs_r               <= 5'd0;
      settle_r           <= 8'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      active_halfstrip   <= 5'd0;
      compout_errcnt_rst <= 1'b0;
      fire_pulse         <= 1'b0;
      result_valid       <= 1'b0;
      result_halfstrip   <= 5'd0;
      result_errcnt      <= 16'd0;
      result_timeout     <= 1'b0;
    end else begin
      state_r            <= state_s;
      hs_r               <= hs_s;
      settle_r           <= settle_s;
      busy               <= (state_s != S_IDLE);
      done               <= done_s;
      compout_errcnt_rst <= (state_s == S_CLEAR);
      fire_pulse         <= (state_s == S_FIRE);
      result_valid       <= (state_s == S_REPORT);

      // The injector keeps the last halfstrip until a new one is cleared.
      if (state_s == S_CLEAR) begin
        active_halfstrip <= hs_s;
      end else begin
        active_halfstrip <= active_halfstrip;
      end

      // Result fields only change on capture, so they stay stable in REPORT.
      if (capture_s) begin
        result_halfstrip <= hs_r;
        result_errcnt    <= compout_errcnt;
        result_timeout   <= 1'b0;
      end else if (timeout_capture_s) begin
        result_halfstrip <= hs_r;
        result_errcnt    <= 16'hFFFF;
        result_timeout   <= 1'b1;
      end else begin
        result_halfstrip <= result_halfstrip;
        result_errcnt    <= result_errcnt;
        result_timeout   <= result_timeout;
      end
    end
  end

endmodule

// File: tb/tb_injector_scan_sequencer.sv
// Scoreboard bench for injector_scan_sequencer. The scan plan (which
// halfstrips, in which order) is computed from hs_first/hs_last with modular
// arithmetic; a behavioural injector produces random pulse-train timings and
// random error counts and queues each count it presents. A monitor pops the
// queues whenever a result is accepted.

module tb_injector_scan_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  hs_first = 5'd0;
  logic [4:0]  hs_last = 5'd0;
  logic [7:0]  settle_cycles = 8'd0;
  logic        busy;
  logic        done;
  logic [4:0]  active_halfstrip;
  logic        compout_errcnt_rst;
  logic        fire_pulse;
  logic        pulser_ready;
  logic [15:0] compout_errcnt;
  logic        result_valid;
  logic        result_ready;
  logic [4:0]  result_halfstrip;
  logic [15:0] result_errcnt;
  logic        result_timeout;

  int vectors = 0;
  int miscompares = 0;

  // Expected data
  logic [4:0]  exp_hs[$];    // result halfstrips in order
  logic [4:0]  exp_act[$];   // active_halfstrip seen at each errcnt clear
  logic [16:0] exp_res[$];   // {timeout, errcnt} per result
  logic [4:0]  tb_last = 5'd0;

  // Monitor-owned counters, read by the main sequence
  int fire_cnt = 0;
  int rst_cnt = 0;
  int done_cnt = 0;
  int hold_req = 0;          // bump to hold result_ready low for the next result
  logic stuck_high = 1'b0;   // injector never answers a fire

  injector_scan_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .abort              (abort),
    .hs_first           (hs_first),
    .hs_last            (hs_last),
    .settle_cycles      (settle_cycles),
    .busy               (busy),
    .done               (done),
    .active_halfstrip   (active_halfstrip),
    .compout_errcnt_rst (compout_errcnt_rst),
    .fire_pulse         (fire_pulse),
    .pulser_ready       (pulser_ready),
    .compout_errcnt     (compout_errcnt),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .result_halfstrip   (result_halfstrip),
    .result_errcnt      (result_errcnt),
    .result_timeout     (result_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Behavioural injector: random delay, random low time, random errcnt
  initial begin
    int phase;
    int wait_n;
    int len_n;
    logic [15:0] errv;
    phase = 0;
    wait_n = 0;
    len_n = 0;
    pulser_ready = 1'b1;
    compout_errcnt = 16'h0000;
    forever begin
      @(negedge clock);
      if (!reset) begin
        phase = 0;
        pulser_ready = 1'b1;
        compout_errcnt = 16'h0000;
      end else begin
        if (compout_errcnt_rst) compout_errcnt = 16'h0000;
        if (stuck_high) begin
          pulser_ready = 1'b1;
          phase = 0;
        end else begin
          case (phase)
            0: if (fire_pulse) begin
                 wait_n = int'($urandom_range(0, 2));
                 len_n = int'($urandom_range(4, 12));
                 phase = 1;
               end
            1: if (wait_n == 0) begin
                 pulser_ready = 1'b0;
                 phase = 2;
               end else wait_n--;
            2: if (len_n <= 1) begin
                 errv = 16'($urandom);
                 compout_errcnt = errv;
                 pulser_ready = 1'b1;
                 exp_res.push_back({1'b0, errv});
                 phase = 0;
               end else len_n--;
            default: phase = 0;
          endcase
        end
      end
    end
  end

  // Monitor: pulse checks, result scoreboard, hold stability, done pulse
  initial begin
    logic [4:0]  held_hs;
    logic [15:0] held_err;
    logic        held_tmo;
    logic        holding;
    logic        done_exp;
    logic        prev_fire;
    logic        prev_rst;
    logic        new_ready;
    logic [4:0]  eh;
    logic [16:0] er;
    int          hold_left;
    int          hold_seen;
    holding = 1'b0; done_exp = 1'b0; prev_fire = 1'b0; prev_rst = 1'b0;
    held_hs = 5'd0; held_err = 16'd0; held_tmo = 1'b0;
    hold_left = 0; hold_seen = 0;
    result_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        holding = 1'b0; done_exp = 1'b0; prev_fire = 1'b0; prev_rst = 1'b0;
        result_ready = 1'b0;
      end else begin
        if (done || done_exp) check("done_pulse", {62'd0, done, busy}, {62'd0, done_exp, 1'b0});
        if (done) done_cnt++;
        done_exp = 1'b0;

        if (fire_pulse) begin
          fire_cnt++;
          check("fire_single", {62'd0, prev_fire, result_valid}, 64'd0);
        end
        prev_fire = fire_pulse;

        if (compout_errcnt_rst) begin
          rst_cnt++;
          if (exp_act.size() == 0) fail_now("unexpected_clear");
          else check("active_hs", {58'd0, prev_rst, active_halfstrip}, {58'd0, 1'b0, exp_act.pop_front()});
        end
        prev_rst = compout_errcnt_rst;

        if (holding)
          check("hold_stable", {41'd0, result_valid, result_halfstrip, result_errcnt, result_timeout},
                {41'd0, 1'b1, held_hs, held_err, held_tmo});

        if (hold_req != hold_seen) begin
          hold_seen = hold_req;
          hold_left = 20;
        end
        if (result_valid && hold_left > 0) begin
          new_ready = 1'b0;
          hold_left--;
        end else begin
          new_ready = ($urandom_range(0, 3) != 0);
        end
        result_ready = new_ready;

        if (result_valid && new_ready) begin
          holding = 1'b0;
          if (exp_hs.size() == 0 || exp_res.size() == 0) begin
            fail_now("unexpected_result");
          end else begin
            eh = exp_hs.pop_front();
            er = exp_res.pop_front();
            check("result", {42'd0, result_halfstrip, result_timeout, result_errcnt},
                  {42'd0, eh, er[16], er[15:0]});
            if (eh == tb_last) done_exp = 1'b1;
          end
        end else if (result_valid) begin
          holding = 1'b1;
          held_hs = result_halfstrip;
          held_err = result_errcnt;
          held_tmo = result_timeout;
        end else begin
          holding = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] out_vec();
    return {busy, done, active_halfstrip, compout_errcnt_rst, fire_pulse,
            result_valid, result_halfstrip, result_errcnt, result_timeout};
  endfunction

  task automatic plan_scan(input logic [4:0] f, input logic [4:0] l);
    int n;
    n = int'(5'(l - f)) + 1;
    tb_last = l;
    for (int i = 0; i < n; i++) begin
      exp_hs.push_back(5'(int'(f) + i));
      exp_act.push_back(5'(int'(f) + i));
    end
  endtask

  task automatic flush_plan();
    exp_hs.delete();
    exp_act.delete();
    exp_res.delete();
  endtask

  task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input logic [7:0] s,
                          input bit poke);
    int n;
    int fire0;
    int rst0;
    int done0;
    int t;
    @(negedge clock);
    hs_first = f;
    hs_last = l;
    settle_cycles = s;
    n = int'(5'(l - f)) + 1;
    plan_scan(f, l);
    fire0 = fire_cnt;
    rst0 = rst_cnt;
    done0 = done_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t = 0;
    while (done_cnt == done0 && t < 5000) begin
      @(negedge clock);
      t++;
      start = (poke && t == 5);
    end
    start = 1'b0;
    if (t >= 5000) fail_now("scan_no_done");
    @(negedge clock);
    check("fire_count", 64'(fire_cnt - fire0), 64'(n));
    check("clear_count", 64'(rst_cnt - rst0), 64'(n));
    check("plan_drained", 64'(exp_hs.size()), 64'd0);
  endtask

  task automatic wait_ready(input logic lvl, inout int t);
    while (pulser_ready !== lvl && t < 300) begin
      @(negedge clock);
      #1;
      t++;
    end
  endtask

  // Main sequence
  initial begin
    int t;
    int done0;
    logic [4:0] f;
    logic [4:0] l;

    repeat (3) @(negedge clock);
    #1;
    check("reset_outputs", 64'(out_vec()), 64'd0);
    reset = 1'b1;

    // single halfstrip
    run_scan(5'd17, 5'd17, 8'd4, 1'b0);
    // wrap through 31->0, with a start poked while busy
    run_scan(5'd30, 5'd1, 8'd2, 1'b1);
    // consumer stalls for 20 cycles on one result
    hold_req++;
    run_scan(5'd5, 5'd5, 8'd0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      f = 5'($urandom_range(0, 31));
      l = 5'(int'(f) + int'($urandom_range(0, 5)));
      run_scan(f, l, 8'($urandom_range(0, 6)), (i == 2));
    end

    // abort during settle
    @(negedge clock);
    hs_first = 5'd10; hs_last = 5'd12; settle_cycles = 8'd20;
    plan_scan(5'd10, 5'd12);
    done0 = done_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t = 0;
    wait_ready(1'b0, t);
    wait_ready(1'b1, t);
    if (t >= 300) fail_now("abort_setup");
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    #1;
    check("abort_idle", {60'd0, busy, result_valid, fire_pulse, done}, 64'd0);
    flush_plan();
    repeat (40) @(negedge clock);
    check("abort_no_done", 64'(done_cnt - done0), 64'd0);
    run_scan(5'd10, 5'd12, 8'd3, 1'b0);

    // reset while waiting for pulser_ready to return high
    @(negedge clock);
    hs_first = 5'd3; hs_last = 5'd8; settle_cycles = 8'd2;
    plan_scan(5'd3, 5'd8);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t = 0;
    wait_ready(1'b0, t);
    if (t >= 300) fail_now("reset_setup");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("reset_mid_wait", 64'(out_vec()), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    flush_plan();
    run_scan(5'd3, 5'd8, 8'd1, 1'b0);

`ifdef SCAN_TIMEOUT_EN
    // pulser never answers: each halfstrip times out and the scan continues
    stuck_high = 1'b1;
    exp_res.push_back(17'h1FFFF);
    exp_res.push_back(17'h1FFFF);
    run_scan(5'd2, 5'd3, 8'd0, 1'b0);
    stuck_high = 1'b0;
`endif

    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound
  initial begin
    #800000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
